// File: rtl/snn_soc_pkg.sv
// Shared SoC constants and the WL receiver state/error encodings.
package snn_soc_pkg;

  localparam int NUM_INPUTS     = 64;
  localparam int WL_GROUP_WIDTH = 8;

  typedef enum logic {
    RX_IDLE,
    RX_COLLECT
  } wl_rx_state_t;

  typedef enum logic [1:0] {
    WL_ERR_NONE  = 2'b00,
    WL_ERR_ORDER = 2'b01,
    WL_ERR_TRUNC = 2'b10
  } wl_rx_err_t;

endpackage

// File: rtl/wl_rx_sat_cnt.sv
// Saturating event counter; clear wins over increment in the same cycle.
module wl_rx_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wl_demux_receiver.sv
// Receive endpoint of the 8-bit time-division WL multiplex: reassembles
// in-order groups into a full bitmap and reports ordering/truncation errors.
module wl_demux_receiver
  import snn_soc_pkg::*;
#(
  parameter int P_NUM_INPUTS = NUM_INPUTS,
  parameter int P_GROUP_W    = WL_GROUP_WIDTH,
  parameter int P_CNT_W      = 16,
  localparam int GROUPS      = P_NUM_INPUTS / P_GROUP_W,
  localparam int SEL_W       = $clog2(GROUPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_GROUP_W-1:0]    wl_data,
  input  logic [SEL_W-1:0]        wl_group_sel,
  input  logic                    wl_latch,
  input  logic                    cnt_clr,
  output logic [P_NUM_INPUTS-1:0] wl_bitmap_out,
  output logic                    wl_valid_pulse_out,
  output logic                    rx_busy,
  output logic                    err_pulse,
  output logic [1:0]              err_code,
  output logic [P_CNT_W-1:0]      frame_cnt,
  output logic [P_CNT_W-1:0]      err_cnt
);

  if ((P_NUM_INPUTS % P_GROUP_W != 0) || (GROUPS < 2)) begin : g_bad_params
    $fatal(1, "wl_demux_receiver: P_NUM_INPUTS must be a multiple of P_GROUP_W with >= 2 groups");
  end

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(GROUPS - 1);

  logic [P_GROUP_W-1:0]    s_data;
  logic [SEL_W-1:0]        s_sel;
  logic                    s_latch;
  wl_rx_state_t            state;
  logic [SEL_W-1:0]        exp_idx;
  logic [P_NUM_INPUTS-1:0] asm_buf;
  wl_rx_err_t              err_code_r;

  logic [P_NUM_INPUTS-1:0] merged;
  logic [P_NUM_INPUTS-1:0] fresh;
  logic                    frame_done;
  logic                    err_now;
  wl_rx_err_t              err_kind;

  // Decode the registered sample into a frame completion or an error event.
  always_comb begin
    merged = asm_buf;
    merged[int'(s_sel)*P_GROUP_W +: P_GROUP_W] = s_data;
    fresh = '0;
    fresh[P_GROUP_W-1:0] = s_data;
    frame_done = 1'b0;
    err_now    = 1'b0;
    err_kind   = WL_ERR_NONE;
    case (state)
      RX_IDLE: begin
        if (s_latch && (s_sel != '0)) begin
          err_now  = 1'b1;
          err_kind = WL_ERR_ORDER;
        end
      end
      RX_COLLECT: begin
        if (!s_latch || (s_sel == '0)) begin
          err_now  = 1'b1;
          err_kind = WL_ERR_TRUNC;
        end else if (s_sel == exp_idx) begin
          frame_done = (exp_idx == LAST_IDX);
        end else begin
          err_now  = 1'b1;
          err_kind = WL_ERR_ORDER;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_data             <= '0;
      s_sel              <= '0;
      s_latch            <= 1'b0;
      state              <= RX_IDLE;
      exp_idx            <= '0;
      asm_buf            <= '0;
      wl_bitmap_out      <= '0;
      wl_valid_pulse_out <= 1'b0;
      err_pulse          <= 1'b0;
      err_code_r         <= WL_ERR_NONE;
    end else begin
      s_data             <= wl_data;
      s_sel              <= wl_group_sel;
      s_latch            <= wl_latch;
      wl_valid_pulse_out <= frame_done;
      err_pulse          <= err_now;
      if (err_now) begin
        err_code_r <= err_kind;
      end
      // A sel=0 sample always opens a new frame, even when it aborts one.
      if (s_latch && (s_sel == '0)) begin
        asm_buf <= fresh;
        exp_idx <= SEL_W'(1);
        state   <= RX_COLLECT;
      end else if (state == RX_COLLECT) begin
        if (s_latch && (s_sel == exp_idx) && (exp_idx != LAST_IDX)) begin
          asm_buf <= merged;
          exp_idx <= exp_idx + SEL_W'(1);
        end else begin
          if (frame_done) begin
            wl_bitmap_out <= merged;
          end
          exp_idx <= '0;
          state   <= RX_IDLE;
        end
      end
    end
  end

  assign rx_busy  = (state == RX_COLLECT);
  assign err_code = err_code_r;

  wl_rx_sat_cnt #(.W(P_CNT_W)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_done),
    .clr (cnt_clr),
    .cnt (frame_cnt)
  );

  wl_rx_sat_cnt #(.W(P_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_now),
    .clr (cnt_clr),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_wl_demux_receiver.sv
// Bench for wl_demux_receiver: directed protocol scenarios plus random traffic
// checked every cycle against a queue-based frame model.
module tb_wl_demux_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wl_data = '0;
  logic [2:0]  wl_group_sel = '0;
  logic        wl_latch = 1'b0;
  logic        cnt_clr = 1'b0;

  logic [63:0] bitmap, bitmap3;
  logic        vpulse, vpulse3, busy, busy3, epulse, epulse3;
  logic [1:0]  ecode, ecode3;
  logic [15:0] fcnt, ecnt;
  logic [2:0]  fcnt3, ecnt3;

  int checks = 0;
  int errors = 0;

  wl_demux_receiver dut (
    .clk(clk), .rst(rst), .wl_data(wl_data), .wl_group_sel(wl_group_sel),
    .wl_latch(wl_latch), .cnt_clr(cnt_clr), .wl_bitmap_out(bitmap),
    .wl_valid_pulse_out(vpulse), .rx_busy(busy), .err_pulse(epulse),
    .err_code(ecode), .frame_cnt(fcnt), .err_cnt(ecnt)
  );

  // Narrow-counter copy on the same pins, so saturation is reachable quickly.
  wl_demux_receiver #(.P_CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .wl_data(wl_data), .wl_group_sel(wl_group_sel),
    .wl_latch(wl_latch), .cnt_clr(cnt_clr), .wl_bitmap_out(bitmap3),
    .wl_valid_pulse_out(vpulse3), .rx_busy(busy3), .err_pulse(epulse3),
    .err_code(ecode3), .frame_cnt(fcnt3), .err_cnt(ecnt3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a frame is a queue of received groups.
  logic [7:0]  m_q[$];
  logic        m_collecting;
  logic [63:0] m_bitmap;
  logic        m_vp, m_ep;
  logic [1:0]  m_code;
  int          m_f16, m_e16, m_f3, m_e3;
  logic        p_lat;
  logic [2:0]  p_sel;
  logic [7:0]  p_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int cur, input logic ev, input logic clr, input int maxv);
    if (clr) return 0;
    if (ev && cur < maxv) return cur + 1;
    return cur;
  endfunction

  task automatic model_edge(input logic r, input logic clr);
    logic ev_f, ev_e;
    logic [63:0] bm;
    ev_f = 1'b0;
    ev_e = 1'b0;
    if (r) begin
      m_q.delete();
      m_collecting = 1'b0;
      m_bitmap = '0; m_vp = 1'b0; m_ep = 1'b0; m_code = 2'b00;
      m_f16 = 0; m_e16 = 0; m_f3 = 0; m_e3 = 0;
      return;
    end
    if (!m_collecting) begin
      if (p_lat && p_sel == 0) begin
        m_q = '{p_dat};
        m_collecting = 1'b1;
      end else if (p_lat) begin
        ev_e = 1'b1; m_code = 2'b01;
      end
    end else if (!p_lat) begin
      ev_e = 1'b1; m_code = 2'b10;
      m_q.delete(); m_collecting = 1'b0;
    end else if (p_sel == 0) begin
      ev_e = 1'b1; m_code = 2'b10;
      m_q = '{p_dat};
    end else if (int'(p_sel) == m_q.size()) begin
      m_q.push_back(p_dat);
      if (m_q.size() == 8) begin
        bm = '0;
        foreach (m_q[i]) bm |= 64'(m_q[i]) << (8 * i);
        m_bitmap = bm;
        ev_f = 1'b1;
        m_q.delete(); m_collecting = 1'b0;
      end
    end else begin
      ev_e = 1'b1; m_code = 2'b01;
      m_q.delete(); m_collecting = 1'b0;
    end
    m_vp = ev_f;
    m_ep = ev_e;
    m_f16 = sat(m_f16, ev_f, clr, 65535);
    m_e16 = sat(m_e16, ev_e, clr, 65535);
    m_f3  = sat(m_f3,  ev_f, clr, 7);
    m_e3  = sat(m_e3,  ev_e, clr, 7);
  endtask

  task automatic cycle(input logic r, input logic l, input logic [2:0] s,
                       input logic [7:0] d, input logic c);
    rst = r; wl_latch = l; wl_group_sel = s; wl_data = d; cnt_clr = c;
    @(posedge clk);
    #1;
    model_edge(r, c);
    if (r) begin
      p_lat = 1'b0; p_sel = '0; p_dat = '0;
    end else begin
      p_lat = l; p_sel = s; p_dat = d;
    end
    chk("bitmap",    bitmap, m_bitmap);
    chk("valid",     64'(vpulse), 64'(m_vp));
    chk("rx_busy",   64'(busy), 64'(m_collecting));
    chk("err_pulse", 64'(epulse), 64'(m_ep));
    chk("err_code",  64'(ecode), 64'(m_code));
    chk("frame_cnt", 64'(fcnt), 64'(m_f16));
    chk("err_cnt",   64'(ecnt), 64'(m_e16));
    chk("frame_cnt3", 64'(fcnt3), 64'(m_f3));
    chk("err_cnt3",  64'(ecnt3), 64'(m_e3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'(i), 8'(i * 37), 1'b0);
  endtask

  task automatic send_groups(input logic [63:0] v, input int first, input int last);
    for (int g = first; g <= last; g++) cycle(1'b0, 1'b1, 3'(g), v[8*g +: 8], 1'b0);
  endtask

  initial begin
    logic [63:0] v;
    int n, bad, kind;
    p_lat = 1'b0; p_sel = '0; p_dat = '0;
    model_edge(1'b1, 1'b0);

    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0);
    chk("reset_bitmap", bitmap, 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    idle(2);

    // Normal frame: pulse two cycles after the last group.
    send_groups(64'h0123_4567_89AB_CDEF, 0, 7);
    chk("normal_no_early_pulse", 64'(vpulse), 64'h0);
    idle(1);
    chk("normal_pulse", 64'(vpulse), 64'h1);
    chk("normal_bitmap", bitmap, 64'h0123_4567_89AB_CDEF);
    chk("normal_frame_cnt", 64'(fcnt), 64'h1);
    chk("normal_err_cnt", 64'(ecnt), 64'h0);
    idle(2);

    // Back-to-back frames.
    send_groups('1, 0, 7);
    send_groups('0, 0, 7);
    idle(1);
    chk("b2b_bitmap_b", bitmap, 64'h0);
    chk("b2b_frame_cnt", 64'(fcnt), 64'h3);
    idle(2);

    // Truncation after group 4.
    send_groups(64'hDEAD_BEEF_CAFE_F00D, 0, 4);
    idle(2);
    chk("trunc_code", 64'(ecode), 64'h2);
    chk("trunc_err_cnt", 64'(ecnt), 64'h1);
    chk("trunc_bitmap_kept", bitmap, 64'h0);
    idle(1);

    // Out of order 0,1,3 then a clean frame.
    send_groups(64'h1111_2222_3333_4444, 0, 1);
    cycle(1'b0, 1'b1, 3'd3, 8'h77, 1'b0);
    idle(1);
    chk("order_code", 64'(ecode), 64'h1);
    send_groups(64'hFEDC_BA98_7654_3210, 0, 7);
    idle(2);
    chk("order_recover_bitmap", bitmap, 64'hFEDC_BA98_7654_3210);

    // Start mid-frame, then early restart.
    cycle(1'b0, 1'b1, 3'd5, 8'h55, 1'b0);
    idle(2);
    chk("midstart_code", 64'(ecode), 64'h1);
    send_groups(64'h0, 0, 2);
    send_groups(64'hA5A5_5A5A_0F0F_F0F0, 0, 7);
    idle(2);
    chk("restart_code", 64'(ecode), 64'h2);
    chk("restart_bitmap", bitmap, 64'hA5A5_5A5A_0F0F_F0F0);

    // Reset in the middle of a frame.
    send_groups(64'h0102_0304_0506_0708, 0, 5);
    cycle(1'b1, 1'b1, 3'd6, 8'h02, 1'b0);
    chk("midreset_err_cnt", 64'(ecnt), 64'h0);
    chk("midreset_bitmap", bitmap, 64'h0);
    idle(3);

    // Clear coincident with a frame completing.
    send_groups(64'h0BAD_F00D_1234_5678, 0, 7);
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("clr_wins_frame_cnt", 64'(fcnt), 64'h0);
    idle(1);

    // Random traffic; enough frames and errors to saturate the narrow copy.
    for (int it = 0; it < 120; it++) begin
      kind = $urandom_range(0, 5);
      v = {$urandom, $urandom};
      n = $urandom_range(1, 6);
      if (kind <= 2) begin
        send_groups(v, 0, 7);
      end else if (kind == 3) begin
        send_groups(v, 0, n);
        cycle(1'b0, 1'b0, 3'($urandom), 8'($urandom), 1'b0);
      end else if (kind == 4) begin
        send_groups(v, 0, n - 1);
        bad = $urandom_range(1, 7);
        while (bad == n) bad = $urandom_range(1, 7);
        cycle(1'b0, 1'b1, 3'(bad), 8'($urandom), 1'b0);
      end else begin
        cycle(1'b0, 1'b1, 3'($urandom_range(1, 7)), 8'($urandom), 1'b0);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--)
        cycle(1'b0, 1'b0, 3'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    idle(3);
    chk("frame_cnt3_saturated", 64'(fcnt3), 64'(m_f3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
